spwm_modulator: RTL and testbench

Three-phase sinusoidal PWM modulator that consumes the 12-bit modulating samples produced by the three-phase sine generator and drives the inverter gate signals. It compares regularly-sampled references against a symmetric triangular carrier and produces complementary high/low gate pairs for each leg, with programmable dead time. It sits between the modulating-wave source and the FPGA gate-driver pins.

---
 rtl/spwm_pkg.sv | 20 ++
 rtl/spwm_modulator_if.sv | 30 +++
 rtl/spwm_leg.sv | 62 ++++++
 rtl/spwm_modulator.sv | 78 +++++++
 tb/tb_spwm_modulator.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spwm_pkg.sv
// Shared widths, constants and leg state type for the three-phase SPWM modulator.
package spwm_pkg;

    localparam int DATA_W           = 12;
    localparam int MID_OFFSET       = 2048;
    localparam int DEAD_CYC_DEFAULT = 12;

    typedef enum logic [1:0] {
        OFF,
        HI,
        LO,
        DEAD
    } leg_state_t;

    // Two's-complement sample plus half scale, done by flipping the sign bit.
    function automatic logic [DATA_W-1:0] to_offset(input logic [DATA_W-1:0] s);
        return {~s[DATA_W-1], s[DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/spwm_modulator_if.sv
// Bus between the modulating-wave source / gate-driver pins and the SPWM modulator.
interface spwm_modulator_if;
    import spwm_pkg::*;

    logic              en;
    logic [DATA_W-1:0] mod_a;
    logic [DATA_W-1:0] mod_b;
    logic [DATA_W-1:0] mod_c;
    logic              gate_a_hi;
    logic              gate_a_lo;
    logic              gate_b_hi;
    logic              gate_b_lo;
    logic              gate_c_hi;
    logic              gate_c_lo;
    logic [DATA_W-1:0] carrier;
    logic              sample_stb;

    modport master (
        output en, mod_a, mod_b, mod_c,
        input  gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo, gate_c_hi, gate_c_lo,
        input  carrier, sample_stb
    );

    modport slave (
        input  en, mod_a, mod_b, mod_c,
        output gate_a_hi, gate_a_lo, gate_b_hi, gate_b_lo, gate_c_hi, gate_c_lo,
        output carrier, sample_stb
    );

endinterface

// File: rtl/spwm_leg.sv
// One inverter leg: complementary gate pair with a fixed dead time on every hand-over.
module spwm_leg
    import spwm_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_dem,
    output logic o_gate_hi,
    output logic o_gate_lo
);

    localparam int CNT_W = $clog2(DEAD_CYC + 1);

    leg_state_t       r_state;
    leg_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_dead_cnt;
    logic             w_dead_done;

    assign w_dead_done = (r_dead_cnt == CNT_W'(DEAD_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter sits at zero outside DEAD, so it is zero on the first DEAD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dead_cnt <= '0;
        end else begin
            r_dead_cnt <= (r_state == DEAD) ? r_dead_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_nxt = r_state;
        if (!i_en) begin
            w_state_nxt = OFF;
        end else begin
            case (r_state)
                OFF:     w_state_nxt = DEAD;
                HI:      if (!i_dem) w_state_nxt = DEAD;
                LO:      if (i_dem) w_state_nxt = DEAD;
                DEAD:    if (w_dead_done) w_state_nxt = i_dem ? HI : LO;
                default: w_state_nxt = OFF;
            endcase
        end
    end

    always_comb begin
        o_gate_hi = (r_state == HI);
        o_gate_lo = (r_state == LO);
    end

endmodule

// File: rtl/spwm_modulator.sv
// Three-phase SPWM: symmetric triangular carrier, regular sampling at both carrier
// turning points, registered per-phase demand compare and three dead-time legs.
module spwm_modulator
    import spwm_pkg::*;
#(
    parameter int CARRIER_MAX = 4095,
    parameter int DEAD_CYC    = DEAD_CYC_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    spwm_modulator_if.slave bus
);

    localparam logic [DATA_W-1:0] C_MAX = DATA_W'(CARRIER_MAX);
    localparam logic [DATA_W-1:0] C_MID = DATA_W'(MID_OFFSET);

    logic [DATA_W-1:0]            r_carrier;
    logic                         r_dir_up;
    logic [2:0][DATA_W-1:0]       r_ref;
    logic [2:0]                   r_dem;
    logic [2:0][DATA_W-1:0]       w_mod;
    logic                         w_turn;
    logic [2:0]                   w_hi;
    logic [2:0]                   w_lo;

    assign w_mod  = {bus.mod_c, bus.mod_b, bus.mod_a};
    assign w_turn = (r_carrier == C_MAX) || (r_carrier == '0);

    // Direction flips on the same edge the count lands on a turning point.
    always_ff @(posedge clk) begin
        // NOTE: nonblocking so every register here sees the pre-edge values of the others.
        if (rst) begin
            r_carrier <= '0;
            r_dir_up  <= 1'b1;
        end else if (r_dir_up) begin
            r_carrier <= r_carrier + 1'b1;
            if (r_carrier == C_MAX - 1'b1) r_dir_up <= 1'b0;
        end else begin
            r_carrier <= r_carrier - 1'b1;
            if (r_carrier == DATA_W'(1)) r_dir_up <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref <= {3{C_MID}};
            r_dem <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_turn) r_ref[i] <= to_offset(w_mod[i]);
                r_dem[i] <= (r_ref[i] > r_carrier);
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_leg
        spwm_leg #(
            .DEAD_CYC (DEAD_CYC)
        ) u_leg (
            .clk       (clk),
            .rst       (rst),
            .i_en      (bus.en),
            .i_dem     (r_dem[g]),
            .o_gate_hi (w_hi[g]),
            .o_gate_lo (w_lo[g])
        );
    end

    assign bus.carrier    = r_carrier;
    assign bus.sample_stb = w_turn & ~rst;
    assign bus.gate_a_hi  = w_hi[0];
    assign bus.gate_a_lo  = w_lo[0];
    assign bus.gate_b_hi  = w_hi[1];
    assign bus.gate_b_lo  = w_lo[1];
    assign bus.gate_c_hi  = w_hi[2];
    assign bus.gate_c_lo  = w_lo[2];

endmodule

// File: tb/tb_spwm_modulator.sv
// Self-checking bench for spwm_modulator: cycle model of carrier, sampling and legs,
// plus directed window counts for duty, saturation, sampling and enable behaviour.
module tb_spwm_modulator;
    import spwm_pkg::*;

    localparam int CMAX   = 4095;
    localparam int DC     = DEAD_CYC_DEFAULT;
    localparam int PERIOD = 2 * CMAX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spwm_modulator_if bus();

    spwm_modulator #(
        .CARRIER_MAX (CMAX),
        .DEAD_CYC    (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [2:0] hi;
    logic [2:0] lo;
    logic [5:0] g;
    assign hi = {bus.gate_c_hi, bus.gate_b_hi, bus.gate_a_hi};
    assign lo = {bus.gate_c_lo, bus.gate_b_lo, bus.gate_a_lo};
    assign g  = {hi, lo};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset, latched references, registered demand,
    // and per leg an enabled flag, remaining dead cycles and the conducting side.
    bit m_valid = 1'b0;
    int m_t;
    int m_ref  [3];
    bit m_dem  [3];
    bit m_act  [3];
    int m_dead [3];
    bit m_side [3];

    function automatic int tri_at(input int t);
        int p;
        p = t % PERIOD;
        return (p <= CMAX) ? p : PERIOD - p;
    endfunction

    // Demand is high for carrier values 0..r-1: zero once, the rest twice per period.
    function automatic int hi_width(input int r);
        return 2 * r - 1 - DC;
    endfunction

    function automatic logic [5:0] exp_gates();
        logic [2:0] eh;
        logic [2:0] el;
        for (int i = 0; i < 3; i++) begin
            eh[i] = m_act[i] && (m_dead[i] == 0) && m_side[i];
            el[i] = m_act[i] && (m_dead[i] == 0) && !m_side[i];
        end
        return {eh, el};
    endfunction

    task automatic model_step();
        logic [DATA_W-1:0] mods [3];
        int c;
        bit dem_now;
        mods[0] = bus.mod_a;
        mods[1] = bus.mod_b;
        mods[2] = bus.mod_c;
        if (rst) begin
            m_valid = 1'b1;
            m_t     = 0;
            for (int i = 0; i < 3; i++) begin
                m_ref[i]  = MID_OFFSET;
                m_dem[i]  = 1'b0;
                m_act[i]  = 1'b0;
                m_dead[i] = 0;
                m_side[i] = 1'b0;
            end
        end else if (m_valid) begin
            c = tri_at(m_t);
            for (int i = 0; i < 3; i++) begin
                dem_now  = m_dem[i];
                m_dem[i] = (m_ref[i] > c);
                if (c == 0 || c == CMAX) m_ref[i] = int'($signed(mods[i])) + MID_OFFSET;
                if (!bus.en) begin
                    m_act[i] = 1'b0;
                end else if (!m_act[i]) begin
                    m_act[i]  = 1'b1;
                    m_dead[i] = DC;
                end else if (m_dead[i] > 0) begin
                    if (m_dead[i] == 1) m_side[i] = dem_now;
                    m_dead[i]--;
                end else if (dem_now != m_side[i]) begin
                    m_dead[i] = DC;
                end
            end
            m_t++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        int c;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                c = tri_at(m_t);
                check("carrier", bus.carrier, c);
                check("sample_stb", bus.sample_stb, (!rst && (c == 0 || c == CMAX)));
                check("gates", g, exp_gates());
                check("hi_lo_overlap", hi & lo, 0);
            end
        end
    end

    // Model-independent dead-time monitor on every hi<->lo hand-over.
    initial begin
        int gap  [3];
        int last [3];
        int cur;
        for (int i = 0; i < 3; i++) begin
            gap[i]  = 0;
            last[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                cur = hi[i] ? 1 : (lo[i] ? 2 : 0);
                if (cur == 0) begin
                    gap[i]++;
                end else begin
                    if (last[i] != 0 && cur != last[i])
                        check("dead_gap", (gap[i] < DC) ? gap[i] : DC, DC);
                    last[i] = cur;
                    gap[i]  = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_carrier(input int val, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.carrier != DATA_W'(val) && n < budget);
        check(name, bus.carrier, val);
    endtask

    function automatic logic [DATA_W-1:0] rand_mod();
        case ($urandom_range(0, 5))
            0:       return 12'h7FF;
            1:       return 12'h800;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    initial begin
        int hi_cnt [3];
        int lo_cnt [3];
        int n;
        int hold;
        int b_hi;
        int a_hi_seen;
        int a_lo_miss;

        bus.en    = 1'b0;
        bus.mod_a = '0;
        bus.mod_b = '0;
        bus.mod_c = '0;
        rst       = 1'b1;

        // Reset state, then first strobe right after release.
        repeat (5) tick();
        @(negedge clk);
        check("reset_gates", g, 0);
        check("reset_carrier", bus.carrier, 0);
        check("reset_stb", bus.sample_stb, 0);
        tick();
        rst    = 1'b0;
        bus.en = 1'b1;
        @(negedge clk);
        check("first_stb", bus.sample_stb, 1);
        check("first_stb_carrier", bus.carrier, 0);

        // Zero modulation: one steady period, trough to trough.
        repeat (10) @(negedge clk);
        wait_carrier(0, PERIOD + 20, "sync_trough");
        for (int i = 0; i < 3; i++) begin
            hi_cnt[i] = 0;
            lo_cnt[i] = 0;
        end
        for (int k = 0; k < PERIOD; k++) begin
            for (int i = 0; i < 3; i++) begin
                hi_cnt[i] += int'(hi[i]);
                lo_cnt[i] += int'(lo[i]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            check("zero_mod_hi_width", hi_cnt[i], 4083);
            check("zero_mod_lo_width", lo_cnt[i], 4083);
        end

        // Sampling: mod_b changes mid up-ramp, takes effect only from the next peak.
        wait_carrier(CMAX, PERIOD + 20, "sync_peak");
        b_hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == CMAX + 1000) bus.mod_b = 12'h400;
            b_hi += int'(bus.gate_b_hi);
            @(negedge clk);
        end
        check("b_hi_before_latch", b_hi, hi_width(MID_OFFSET));
        b_hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            b_hi += int'(bus.gate_b_hi);
            @(negedge clk);
        end
        check("b_hi_after_latch", b_hi, hi_width(1024 + MID_OFFSET));

        // Random modulation including both saturation extremes.
        n = 0;
        while (n < 12000) begin
            hold      = $urandom_range(200, 3000);
            bus.mod_a = rand_mod();
            bus.mod_b = rand_mod();
            bus.mod_c = rand_mod();
            repeat (hold) tick();
            n += hold;
        end

        // Enable: drop mid-HI, then re-raise and count the blank cycles.
        bus.mod_a = '0;
        bus.mod_b = '0;
        bus.mod_c = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gate_a_hi !== 1'b1 && n < 2 * PERIOD);
        check("wait_a_hi", bus.gate_a_hi, 1);
        tick();
        bus.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_fall_gates", g, 0);
        repeat (5) tick();
        bus.en = 1'b1;
        n = 0;
        @(negedge clk);
        while (g == 6'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("en_rise_blank_cycles", n, DC + 1);

        // Mid-run reset with enable held high.
        tick();
        rst = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("midrun_reset_gates", g, 0);
        check("midrun_reset_carrier", bus.carrier, 0);
        check("midrun_reset_stb", bus.sample_stb, 0);
        tick();
        rst       = 1'b0;
        bus.mod_a = 12'h800;
        @(negedge clk);
        check("midrun_first_stb", bus.sample_stb, 1);
        check("midrun_first_carrier", bus.carrier, 0);

        // Saturation: ref_a = 0, leg A must sit on the low gate once dead time ends.
        a_hi_seen = 0;
        a_lo_miss = 0;
        for (int k = 0; k < 9000; k++) begin
            if (bus.gate_a_hi) a_hi_seen++;
            if (k > DC && !bus.gate_a_lo) a_lo_miss++;
            @(negedge clk);
        end
        check("sat_a_hi_cycles", a_hi_seen, 0);
        check("sat_a_lo_missing", a_lo_miss, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
